// File: rtl/multiply_pkg.sv
// Shared state encoding and sizing helpers for the sequential shift-add multiplier.
// MULTIPLY_SEQ_SIGNED_EN selects the two's-complement build in multiply_seq.
package multiply_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiply_sign_adjust.sv
// Conditional two's-complement negation.
// Used for operand magnitudes and for the final product sign.
module multiply_sign_adjust #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/multiply_seq.sv
// Iterative shift-add multiplier with valid/ready ports: one accumulate step per cycle.
// Define MULTIPLY_SEQ_SIGNED_EN to honour is_signed; otherwise every operand is unsigned.
module multiply_seq
    import multiply_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               res_neg;
    logic [2*WIDTH-1:0] prod_final;

    // Add into the upper half with a carry bit, then shift the whole accumulator right.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[WIDTH-1:1]};
    end

`ifdef MULTIPLY_SEQ_SIGNED_EN
    logic a_neg;
    logic b_neg;

    assign a_neg   = is_signed & multiplicand[WIDTH-1];
    assign b_neg   = is_signed & multiplier[WIDTH-1];
    assign res_neg = a_neg ^ b_neg;

    multiply_sign_adjust #(.WIDTH(WIDTH)) u_abs_a (
        .value  (multiplicand),
        .negate (a_neg),
        .result (a_mag)
    );

    multiply_sign_adjust #(.WIDTH(WIDTH)) u_abs_b (
        .value  (multiplier),
        .negate (b_neg),
        .result (b_mag)
    );

    multiply_sign_adjust #(.WIDTH(2 * WIDTH)) u_res (
        .value  (acc_next),
        .negate (neg),
        .result (prod_final)
    );
`else
    logic [1:0] unused_signed;

    assign a_mag         = multiplicand;
    assign b_mag         = multiplier;
    assign res_neg       = 1'b0;
    assign prod_final    = acc_next;
    assign unused_signed = {is_signed, neg};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= res_neg;
                        acc    <= '0;
                        count  <= '0;
                        state  <= StBusy;
                    end
                end
                StBusy: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // Final step: capture the sign-corrected product so DONE holds it stable.
                    if (count == CW'(WIDTH - 1)) begin
                        product <= prod_final;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state == StIdle);
    assign busy      = (state == StBusy);
    assign out_valid = (state == StDone);

endmodule

// File: doc/multiply_seq.md
# multiply_seq

Parametrised iterative shift-add multiplier: successor to the 16-bit combinational unsigned parallel multiplier, generalised to any operand width, registered, and handshaked. Consumes one operand pair through a valid/ready input port, computes a 2·WIDTH-bit product in WIDTH cycles using a single adder, and holds the result on a valid/ready output port. Intended for datapaths where area matters more than throughput.

## Interface
- WIDTH, 16, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- multiplicand  input  WIDTH  operand A
- multiplier  input  WIDTH  operand B
- is_signed  input  1  treat operands as two's complement (see Configuration)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2·WIDTH  A·B
- busy  output  1  high in BUSY state

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch |A|, |B| (raw operands if unsigned), latch result sign = sign(A) XOR sign(B) when signed, clear accumulator, counter=0, go BUSY.
- BUSY: each cycle, if multiplier LSB set, add shifted multiplicand into the upper half of the accumulator; shift the accumulator/multiplier right by one; counter++. After WIDTH BUSY cycles, go DONE.
- DONE: out_valid=1. product = accumulator, or its two's-complement negation if result sign set. Hold product stable while out_ready=0. On out_ready go IDLE.
- in_ready is high only in IDLE; no acceptance in the same cycle a result is drained.
- Arithmetic: unsigned uses WIDTH-bit magnitudes, carry captured in a WIDTH+1-bit adder; product never overflows 2·WIDTH bits. Signed: magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), representable unsigned; negation is modulo 2^(2·WIDTH).
- Inputs outside IDLE are ignored; in_valid during BUSY/DONE is not lost and is accepted after returning to IDLE.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, counter=0. Reset takes priority in any state, including mid-BUSY and DONE with out_ready=0; the in-flight result is discarded.
- Accept at edge k → BUSY after edge k; DONE (out_valid=1) after edge k+WIDTH.
- out_valid/out_ready both high at edge m → IDLE after m; next acceptance earliest at edge m+1.
- Minimum throughput: one result per WIDTH+2 cycles.
- product, out_valid, in_ready, busy are registered or decoded from registered state only; no combinational path from inputs to outputs.

## Configuration
- MULTIPLY_SEQ_SIGNED_EN defined: is_signed honoured; signed operands converted to magnitude on accept, result negated in DONE when signs differ.
- Undefined: is_signed ignored, all operands unsigned; the sign-adjust logic is not instantiated. Port list unchanged.

## Structure
- Package multiply_pkg: state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), counter-width function (clog2 of WIDTH+1).
- One sub-module: multiply_sign_adjust (combinational conditional two's-complement negate, parametrised width), used for operand magnitude and result negation; instantiated only under MULTIPLY_SEQ_SIGNED_EN.

## Test plan
- WIDTH=16, unsigned: A=0x1111, B=0x0001, 0x0011, 0x0111, 0x1111 → product 0x00001111, 0x00012221, 0x00123321, 0x01234321; out_valid exactly 16 cycles after acceptance.
- Unsigned extreme: 0xFFFF×0xFFFF → 0xFFFE0001; 0x0000×0xFFFF → 0x00000000.
- Signed (macro defined, is_signed=1): 0xFFFF×0x0002 → 0xFFFFFFFE; 0x8000×0x8000 → 0x40000000; 0x8000×0x0001 → 0xFFFF8000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → product stable, in_ready=0, in_valid ignored; release → IDLE next cycle, queued in_valid accepted one cycle later.
- Reset mid-BUSY (cycle 7 of 16) → next cycle all outputs at reset values; a fresh 0x0003×0x0005 then yields 0x0000000F.
- WIDTH=8 build without macro, is_signed=1: 0xFF×0xFF → 0xFE01 (unsigned).
